my_irq_v1_0: RTL and testbench
==============================

MY_IRQ_V1_0 -- requirements
Module: my_irq_v1_0

Interface
REQ-001 SHALL have parameter C_S00_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 supported.
REQ-002 SHALL have parameter C_S00_AXI_ADDR_WIDTH, default 7, AXI4-Lite byte-address width (32 word registers).
REQ-003 SHALL use one clock; reset is asynchronous and active-low: s00_axi_aclk input 1 (clock, all logic rising-edge), s00_axi_aresetn input 1 (reset).
REQ-004 SHALL have write-address ports: s00_axi_awaddr in 7; s00_axi_awprot in 3 (ignored); s00_axi_awvalid in 1; s00_axi_awready out 1.
REQ-005 SHALL have write-data ports: s00_axi_wdata in 32; s00_axi_wstrb in 4 (byte enables); s00_axi_wvalid in 1; s00_axi_wready out 1.
REQ-006 SHALL have write-response ports: s00_axi_bresp out 2 (always 2'b00 OKAY); s00_axi_bvalid out 1; s00_axi_bready in 1.
REQ-007 SHALL have read ports: s00_axi_araddr in 7; s00_axi_arprot in 3 (ignored); s00_axi_arvalid in 1; s00_axi_arready out 1; s00_axi_rdata out 32; s00_axi_rresp out 2 (always 2'b00); s00_axi_rvalid out 1; s00_axi_rready in 1.
REQ-008 SHALL have PWM_OUT output 8: one PWM waveform per channel.

Function
REQ-009 Register map, word index = addr[6:2]: 0x00 CTRL[7:0] channel enables; 0x04 PERIOD[15:0]; 0x08+4*i DUTY_i[15:0], i=0..7; 0x28 COUNT[15:0] read-only; 0x2C POLARITY[7:0] (see REQ-023); all other addresses read 0, writes ignored; unused upper bits read 0.
REQ-010 Write: awready and wready SHALL pulse high together for one cycle when awvalid and wvalid both high and awready low; register updated same edge, per-byte per wstrb.
REQ-011 bvalid SHALL rise the cycle after the write handshake and hold until bready sampled high; no new write accepted while bvalid high.
REQ-012 Read: arready SHALL pulse one cycle when arvalid high, arready low and rvalid low; rdata/rvalid valid next cycle, held stable until rready sampled high.
REQ-013 Write to COUNT SHALL be ignored; read SHALL return live counter.
REQ-014 Counter: 16-bit, advances +1 per clock while CTRL != 0; at value PERIOD wraps to 0 (period = PERIOD+1 cycles); held at 0 while CTRL == 0.
REQ-015 PERIOD and DUTY_i writes SHALL go to shadow registers; active copies load at wrap (counter == PERIOD) and whenever CTRL == 0.
REQ-016 PWM_OUT[i] SHALL be registered: next value = CTRL[i] and (counter < active DUTY_i); one-cycle latency from counter.
REQ-017 Boundary: DUTY_i = 0 -> constant low; DUTY_i > PERIOD -> constant high while enabled; PERIOD = 0 -> counter stays 0.
REQ-018 Clearing CTRL[i] SHALL force PWM_OUT[i] low on next edge; other channels unaffected.
REQ-019 Simultaneous AXI write of PERIOD/DUTY and counter wrap: active copies load the pre-write shadow value; new value applies at next wrap.

Reset
REQ-020 On s00_axi_aresetn low (asynchronous): all ready/valid outputs 0, rdata 0, CTRL/PERIOD/DUTY/shadows/POLARITY/counter 0, PWM_OUT 0.
REQ-021 Reset mid-transaction SHALL abort it; no response issued after release.
REQ-022 Reset deassertion SHALL be synchronised to s00_axi_aclk internally (two-flop) before releasing logic.

Configuration
REQ-023 Macro MY_IRQ_POLARITY_EN defined: POLARITY register at 0x2C read/write; PWM_OUT[i] = REQ-016 value XOR POLARITY[i] when CTRL[i]=1, still 0 when disabled. Undefined: 0x2C reads 0, writes ignored, outputs active-high.

Verification
REQ-024 Reset 1000 ns, release -> all outputs 0; read 0x00 returns 0x00000000, rresp 0.
REQ-025 Write 0x04=9, 0x08=3, 0x00=0x01 -> PWM_OUT[0] high 3 / low 7 cycles, period 10 cycles; bvalid one response per write.
REQ-026 Write DUTY_1=0 and DUTY_2=0xFFFF, PERIOD=4, CTRL=0x06 -> PWM_OUT[1] constant 0, PWM_OUT[2] constant 1.
REQ-027 Change DUTY_0 from 3 to 6 mid-period -> old duty finishes current period, 6 high cycles from next period.
REQ-028 Write 0x7C=0xDEADBEEF, read 0x7C -> 0; read 0x28 repeatedly -> increasing values wrapping at PERIOD; rready held low 3 cycles keeps rvalid/rdata stable.
REQ-029 With MY_IRQ_POLARITY_EN, POLARITY=0x01 in REQ-025 setup -> PWM_OUT[0] low 3 / high 7 cycles.

Source files
------------

// File: rtl/my_irq_v1_0.sv
// 8-channel PWM generator behind an AXI4-Lite register slave.
// Define MY_IRQ_POLARITY_EN to add the per-channel POLARITY register.
module my_irq_v1_0 #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 7
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [7:0]                        PWM_OUT
);

  logic        clk;
  logic        rst_n;
  logic [1:0]  rst_sync;
  logic        aw_rdy;
  logic        b_vld;
  logic        ar_rdy;
  logic        r_vld;
  logic [31:0] r_data;
  logic [31:0] rd_val;
  logic        wr_en;
  logic        rd_hs;
  logic [4:0]  widx;
  logic [4:0]  ridx;
  logic [2:0]  wdi;
  logic [2:0]  rdi;
  logic [7:0]  ctrl;
  logic [15:0] period_sh;
  logic [15:0] period_act;
  logic [15:0] cnt;
  logic [15:0] duty_sh [8];
  logic [15:0] duty_act [8];
  logic [7:0]  pol;
  logic [7:0]  pwm;
  logic [7:0]  pwm_nxt;
  logic        run;
  logic        wrap;
  logic        unused_ok;

  assign clk = s00_axi_aclk;

  // Async assert, two-flop synchronised release.
  always_ff @(posedge clk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) rst_sync <= 2'b00;
    else                  rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  function automatic logic [15:0] merge16(
    input logic [15:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    return {s[1] ? d[15:8] : old[15:8],
            s[0] ? d[7:0]  : old[7:0]};
  endfunction

  assign widx  = s00_axi_awaddr[6:2];
  assign ridx  = s00_axi_araddr[6:2];
  assign wdi   = 3'(widx - 5'd2);
  assign rdi   = 3'(ridx - 5'd2);
  assign wr_en = aw_rdy & s00_axi_awvalid & s00_axi_wvalid;
  assign rd_hs = ar_rdy & s00_axi_arvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_rdy <= 1'b0;
      b_vld  <= 1'b0;
    end else begin
      aw_rdy <= ~aw_rdy & ~b_vld
              & s00_axi_awvalid & s00_axi_wvalid;
      if (wr_en)               b_vld <= 1'b1;
      else if (s00_axi_bready) b_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_rdy <= 1'b0;
      r_vld  <= 1'b0;
      r_data <= '0;
    end else begin
      ar_rdy <= ~ar_rdy & ~r_vld & s00_axi_arvalid;
      if (rd_hs) begin
        r_vld  <= 1'b1;
        r_data <= rd_val;
      end else if (s00_axi_rready) begin
        r_vld  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl      <= '0;
      period_sh <= '0;
      for (int i = 0; i < 8; i++) duty_sh[i] <= '0;
    end else if (wr_en) begin
      unique case (1'b1)
        (widx == 5'd0):
          if (s00_axi_wstrb[0]) ctrl <= s00_axi_wdata[7:0];
        (widx == 5'd1):
          period_sh <= merge16(period_sh, s00_axi_wdata, s00_axi_wstrb);
        (widx >= 5'd2 && widx <= 5'd9):
          duty_sh[wdi] <= merge16(duty_sh[wdi], s00_axi_wdata, s00_axi_wstrb);
        default: ;
      endcase
    end
  end

`ifdef MY_IRQ_POLARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pol <= '0;
    else if (wr_en && widx == 5'd11 && s00_axi_wstrb[0])
      pol <= s00_axi_wdata[7:0];
  end
`else
  assign pol = 8'h00;
`endif

  // Active copies follow the shadows while idle and reload at each wrap.
  assign run  = |ctrl;
  assign wrap = run && (cnt == period_act);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      period_act <= '0;
      for (int i = 0; i < 8; i++) duty_act[i] <= '0;
    end else if (!run || wrap) begin
      cnt        <= '0;
      period_act <= period_sh;
      for (int i = 0; i < 8; i++) duty_act[i] <= duty_sh[i];
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  always_comb begin
    pwm_nxt = '0;
    for (int i = 0; i < 8; i++)
      pwm_nxt[i] = ctrl[i] & ((cnt < duty_act[i]) ^ pol[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm <= '0;
    else        pwm <= pwm_nxt;
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      (ridx == 5'd0):                 rd_val = {24'h0, ctrl};
      (ridx == 5'd1):                 rd_val = {16'h0, period_sh};
      (ridx >= 5'd2 && ridx <= 5'd9): rd_val = {16'h0, duty_sh[rdi]};
      (ridx == 5'd10):                rd_val = {16'h0, cnt};
      (ridx == 5'd11):                rd_val = {24'h0, pol};
      default:                        rd_val = '0;
    endcase
  end

  assign s00_axi_awready = aw_rdy;
  assign s00_axi_wready  = aw_rdy;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_bvalid  = b_vld;
  assign s00_axi_arready = ar_rdy;
  assign s00_axi_rdata   = r_data;
  assign s00_axi_rresp   = 2'b00;
  assign s00_axi_rvalid  = r_vld;
  assign PWM_OUT         = pwm;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                       s00_axi_wdata[31:16], s00_axi_wstrb[3:2]};

endmodule

// File: tb/tb_my_irq_v1_0.sv
// Scoreboard bench for my_irq_v1_0: AXI responses and every PWM
// sample are checked against an edge-indexed register-history model.
module tb_my_irq_v1_0;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [6:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [6:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [7:0]  pwm_out;

  my_irq_v1_0 #(
    .C_S00_AXI_DATA_WIDTH(32),
    .C_S00_AXI_ADDR_WIDTH(7)
  ) dut (
    .s00_axi_aclk(clk),       .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr),  .s00_axi_awprot(awprot),
    .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata),    .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid),  .s00_axi_wready(wready),
    .s00_axi_bresp(bresp),    .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready),
    .s00_axi_araddr(araddr),  .s00_axi_arprot(arprot),
    .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata),    .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid),  .s00_axi_rready(rready),
    .PWM_OUT(pwm_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  function automatic void chk(input string nm, input longint act,
                              input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               nm, act, want, cyc);
    end
  endfunction

  // Register history: ch 0-7 DUTY shadows, 8 CTRL, 9 POLARITY, 10 PERIOD.
  // An entry at cycle w holds the register value after clock edge w.
  typedef struct {int cyc; int ch; int val;} ev_t;
  ev_t hist[$];
  int  en_cyc = 0;
  int  rexp[$];
  int  wexp[$];

  function automatic int val_at(input int ch, input int k);
    for (int n = hist.size() - 1; n >= 0; n--)
      if (hist[n].ch == ch && hist[n].cyc <= k) return hist[n].val;
    return 0;
  endfunction

  function automatic int per_len();
    return val_at(10, en_cyc - 1) + 1;
  endfunction

  // Counter after edge k: k-en_cyc cycles into the run, modulo PERIOD+1.
  function automatic int count_after(input int k);
    if (val_at(8, k - 1) == 0) return 0;
    return (k - en_cyc) % per_len();
  endfunction

  // Active duty after edge j = shadow as it stood before the edge that
  // started the current period (or before j itself while disabled).
  function automatic int duty_act_after(input int ch, input int j);
    int s;
    if (val_at(8, j - 1) == 0) s = j;
    else s = en_cyc + ((j - en_cyc) / per_len()) * per_len();
    return val_at(ch, s - 1);
  endfunction

  function automatic logic [7:0] pwm_exp(input int k);
    logic [7:0] c;
    logic [7:0] p;
    logic [7:0] r;
    int cn;
    c  = 8'(val_at(8, k - 1));
    p  = 8'(val_at(9, k - 1));
    cn = count_after(k - 1);
    for (int i = 0; i < 8; i++)
      r[i] = c[i] & ((cn < duty_act_after(i, k - 1)) ^ p[i]);
    return r;
  endfunction

  function automatic void model_wr(input logic [6:0] a, input logic [31:0] d,
                                   input logic [3:0] s, input int w);
    int idx;
    int ch;
    logic [15:0] o;
    logic [15:0] n;
    idx = int'(a[6:2]);
    ch  = -1;
    if (idx == 0) ch = 8;
    else if (idx == 1) ch = 10;
    else if (idx >= 2 && idx <= 9) ch = idx - 2;
`ifdef MY_IRQ_POLARITY_EN
    if (idx == 11) ch = 9;
`endif
    if (ch < 0) return;
    o = 16'(val_at(ch, w));
    if (ch == 8 || ch == 9) n = {8'h0, s[0] ? d[7:0] : o[7:0]};
    else n = {s[1] ? d[15:8] : o[15:8], s[0] ? d[7:0] : o[7:0]};
    if (ch == 8 && o == 0 && n != 0) en_cyc = w;
    hist.push_back('{w, ch, int'(n)});
  endfunction

  function automatic int model_rd(input logic [6:0] a, input int h);
    int idx;
    int k;
    idx = int'(a[6:2]);
    k   = h - 1;
    if (idx == 0) return val_at(8, k);
    if (idx == 1) return val_at(10, k);
    if (idx >= 2 && idx <= 9) return val_at(idx - 2, k);
    if (idx == 10) return count_after(k);
`ifdef MY_IRQ_POLARITY_EN
    if (idx == 11) return val_at(9, k);
`endif
    return 0;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (bvalid && bready) begin
        if (wexp.size() == 0) chk("bvalid_unexpected", 1, 0);
        else chk("bresp", bresp, wexp.pop_front());
      end
      if (rvalid) begin
        if (rexp.size() == 0) begin
          chk("rvalid_unexpected", 1, 0);
        end else begin
          chk("rdata", rdata, rexp[0]);
          chk("rresp", rresp, 0);
          if (rready) void'(rexp.pop_front());
        end
      end
      chk("pwm_out", pwm_out, pwm_exp(cyc));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_wr(input logic [6:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    int n;
    n = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!awready && n < 20);
    if (!awready) begin
      chk("awready_timeout", 0, 1);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    chk("wready_with_awready", wready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wexp.push_back(0);
    model_wr(a, d, s, cyc);
    n = 0;
    while (bvalid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (bvalid) chk("bvalid_stuck", 1, 0);
  endtask

  task automatic axi_rd(input logic [6:0] a, input int stall);
    int n;
    n = 0;
    araddr = a; arvalid = 1'b1; rready = (stall == 0);
    do begin
      @(posedge clk); #1; n++;
    end while (!arready && n < 20);
    if (!arready) begin
      chk("arready_timeout", 0, 1);
      arvalid = 1'b0; rready = 1'b1;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    rexp.push_back(model_rd(a, cyc));
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 rready = 1'b1;
    end
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (rvalid && n < 20);
    if (rvalid) chk("rvalid_stuck", 1, 0);
    rready = 1'b1;
  endtask

  logic [6:0] rd_addrs [10] = '{7'h00, 7'h04, 7'h08, 7'h14, 7'h24,
                                7'h28, 7'h28, 7'h2C, 7'h30, 7'h7C};
  logic [6:0] junk_addrs [5] = '{7'h28, 7'h2C, 7'h30, 7'h40, 7'h7C};

  initial begin
    int hi;
    int n2;
    int seen;
    int p;
    int d;
    int ch;

    #1000;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_pwm", pwm_out, 0);
    @(negedge clk);
    aresetn = 1'b1;
    cycles(5);
    mon_en = 1'b1;
    axi_rd(7'h00, 0);

    // 10-cycle period, 3 high cycles.
    axi_wr(7'h04, 32'd9, 4'hF);
    axi_wr(7'h08, 32'd3, 4'hF);
    axi_wr(7'h00, 32'h01, 4'hF);
    cycles(5);
    hi = 0;
    repeat (10) begin @(negedge clk); hi += int'(pwm_out[0]); end
    chk("period10_high_cycles", hi, 3);

    // Duty change mid-period lands on the next period.
    cycles(4);
    axi_wr(7'h08, 32'd6, 4'hF);
    cycles(25);
    hi = 0;
    repeat (10) begin @(negedge clk); hi += int'(pwm_out[0]); end
    chk("duty6_high_cycles", hi, 6);

    // Duty 0 and duty beyond the period.
    axi_wr(7'h00, 32'h00, 4'h1);
    axi_wr(7'h0C, 32'h0, 4'h3);
    axi_wr(7'h10, 32'hFFFF, 4'h3);
    axi_wr(7'h04, 32'd4, 4'h3);
    axi_wr(7'h00, 32'h06, 4'h1);
    cycles(5);
    hi = 0; n2 = 0;
    repeat (10) begin
      @(negedge clk);
      hi += int'(pwm_out[1]);
      n2 += int'(pwm_out[2]);
    end
    chk("duty0_high_cycles", hi, 0);
    chk("duty_ffff_high_cycles", n2, 10);

    axi_wr(7'h7C, 32'hDEADBEEF, 4'hF);
    axi_rd(7'h7C, 0);
    axi_wr(7'h28, 32'h1234, 4'hF);
    for (int i = 0; i < 4; i++) axi_rd(7'h28, 0);
    axi_rd(7'h28, 3);

`ifdef MY_IRQ_POLARITY_EN
    axi_wr(7'h00, 32'h00, 4'h1);
    axi_wr(7'h2C, 32'h01, 4'h1);
    axi_wr(7'h04, 32'd9, 4'h3);
    axi_wr(7'h08, 32'd3, 4'h3);
    axi_wr(7'h00, 32'h01, 4'h1);
    axi_rd(7'h2C, 0);
    cycles(5);
    hi = 0;
    repeat (10) begin @(negedge clk); hi += int'(pwm_out[0]); end
    chk("inverted_high_cycles", hi, 7);
    axi_wr(7'h2C, 32'h00, 4'h1);
`endif

    for (int ph = 0; ph < 6; ph++) begin
      axi_wr(7'h00, 32'h0, 4'h1);
      cycles(2);
      p = $urandom_range(0, 12);
      axi_wr(7'h04, {16'($urandom), 16'(p)}, 4'h3);
      for (int c = 0; c < 8; c++) begin
        case ($urandom_range(0, 4))
          0: d = 0;
          1: d = p;
          2: d = p + 1;
          3: d = $urandom_range(0, p + 3);
          default: d = 16'hFFFF;
        endcase
        axi_wr(7'(8 + 4 * c), {16'($urandom), 16'(d)},
               ($urandom_range(0, 3) == 0) ? 4'h1 : 4'h3);
      end
      axi_wr(7'h00, 32'($urandom_range(1, 255)), 4'h1);
      for (int op = 0; op < 10; op++) begin
        case ($urandom_range(0, 4))
          0: cycles($urandom_range(1, 15));
          1: axi_rd(rd_addrs[$urandom_range(0, 9)], $urandom_range(0, 2));
          2: begin
            ch = $urandom_range(0, 7);
            axi_wr(7'(8 + 4 * ch), 32'($urandom_range(0, p + 2)), 4'h3);
          end
          3: axi_wr(7'h00, 32'($urandom_range(0, 255)), 4'($urandom));
          default: axi_wr(junk_addrs[$urandom_range(0, 4)], $urandom, 4'hF);
        endcase
      end
    end

    // Reset in the middle of an accepted-but-unfinished write.
    cycles(3);
    mon_en = 1'b0;
    awaddr = 7'h04; wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    seen = 0;
    do begin
      @(posedge clk); #1; seen++;
    end while (!awready && seen < 20);
    chk("abort_awready", awready, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_awready", awready, 0);
    chk("arst_bvalid", bvalid, 0);
    chk("arst_rvalid", rvalid, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_pwm", pwm_out, 0);
    awvalid = 1'b0; wvalid = 1'b0;
    hist.delete();
    en_cyc = 0;
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      seen += int'(bvalid);
    end
    chk("no_bresp_after_abort", seen, 0);
    mon_en = 1'b1;
    axi_rd(7'h04, 0);
    axi_rd(7'h00, 0);
    cycles(3);

    chk("write_queue_drained", wexp.size(), 0);
    chk("read_queue_drained", rexp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
